// File: rtl/acc.sv
// Accumulator register. Each rising edge it loads, increments or holds, using a fixed priority.
// dataOut is driven straight from the register, so no input reaches it combinationally.
module acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [WIDTH-1:0] aluIn,
  input  logic             write_en,
  input  logic             alu_en,
  input  logic             inc_en,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (write_en) begin
      acc_d = dataIn;
    end else if (alu_en) begin
      acc_d = aluIn;
    end else if (inc_en) begin
      // Wraps modulo 2^WIDTH; the carry is deliberately discarded.
      acc_d = acc_q + WIDTH'(1);
    end
  end

  // rst is tested before acc_d is used, so X on the enables cannot reach the cleared value.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign dataOut = acc_q;

endmodule

// File: tb/tb_acc.sv
// Directed bench for acc, followed by a short randomized run checked against a reference model.
module tb_acc;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] aluIn;
  logic             write_en;
  logic             alu_en;
  logic             inc_en;
  logic [WIDTH-1:0] dataOut;

  int checks = 0;
  int errors = 0;

  acc #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (dataIn),
    .aluIn   (aluIn),
    .write_en(write_en),
    .alu_en  (alu_en),
    .inc_en  (inc_en),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic we, input logic ae, input logic ie,
                       input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] ain);
    rst = r; write_en = we; alu_en = ae; inc_en = ie; dataIn = din; aluIn = ain;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd45, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd0) begin
      errors++;
      $display("FAIL reset_with_write: got %0d expected 0", dataOut);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd77, 16'd0);
    step();
    rst = 1'b1; write_en = 1'bx; alu_en = 1'bx; inc_en = 1'bx;
    step();
    checks++;
    if (dataOut !== 16'd0) begin
      errors++;
      $display("FAIL reset_x_enables: got %h expected 0000", dataOut);
    end
  endtask

  task automatic test_loads();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd30, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd30) begin
      errors++;
      $display("FAIL load_data: got %0d expected 30", dataOut);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd250);
    step();
    checks++;
    if (dataOut !== 16'd250) begin
      errors++;
      $display("FAIL load_alu: got %0d expected 250", dataOut);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd2);
    step();
    checks++;
    if (dataOut !== 16'd250) begin
      errors++;
      $display("FAIL hold_after_alu: got %0d expected 250", dataOut);
    end
  endtask

  task automatic test_priority();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'd50, 16'd500);
    step();
    checks++;
    if (dataOut !== 16'd50) begin
      errors++;
      $display("FAIL prio_write: got %0d expected 50", dataOut);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'd9, 16'd400);
    step();
    checks++;
    if (dataOut !== 16'd400) begin
      errors++;
      $display("FAIL prio_alu: got %0d expected 400", dataOut);
    end
  endtask

  task automatic test_increment();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd35, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (dataOut !== 16'(35 + i)) begin
        errors++;
        $display("FAIL increment_%0d: got %0d expected %0d", i, dataOut, 35 + i);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'h0000) begin
      errors++;
      $display("FAIL increment_wrap: got %h expected 0000", dataOut);
    end
  endtask

  task automatic test_hold_and_sampling();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h5555);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (dataOut !== 16'h1234) begin
      errors++;
      $display("FAIL hold_idle: got %h expected 1234", dataOut);
    end
    // Pulse the enables between edges; nothing may reach dataOut.
    #1 write_en = 1'b1; dataIn = 16'hBEEF;
    #1 checks++;
    if (dataOut !== 16'h1234) begin
      errors++;
      $display("FAIL no_comb_path: got %h expected 1234", dataOut);
    end
    #1 write_en = 1'b0; alu_en = 1'b1;
    #1 alu_en = 1'b0;
    step();
    checks++;
    if (dataOut !== 16'h1234) begin
      errors++;
      $display("FAIL between_edge_glitch: got %h expected 1234", dataOut);
    end
  endtask

  task automatic test_reset_override();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd999, 16'd0);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd321);
    step();
    checks++;
    if (dataOut !== 16'd0) begin
      errors++;
      $display("FAIL reset_override: got %0d expected 0", dataOut);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd1) begin
      errors++;
      $display("FAIL resume_after_reset: got %0d expected 1", dataOut);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd100, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd100) begin
      errors++;
      $display("FAIL b2b_write: got %0d expected 100", dataOut);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd200);
    step();
    checks++;
    if (dataOut !== 16'd200) begin
      errors++;
      $display("FAIL b2b_alu: got %0d expected 200", dataOut);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd201) begin
      errors++;
      $display("FAIL b2b_inc: got %0d expected 201", dataOut);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'd0);
    step();
    checks++;
    if (dataOut !== 16'd5) begin
      errors++;
      $display("FAIL b2b_write2: got %0d expected 5", dataOut);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] model;
    logic             r, we, ae, ie;
    logic [WIDTH-1:0] din, ain;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    step();
    model = '0;
    for (int i = 0; i < 40; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 3) == 0);
      ae  = ($urandom_range(0, 2) == 0);
      ie  = ($urandom_range(0, 1) == 1);
      din = 16'($urandom);
      ain = 16'($urandom);
      if (i % 8 == 3) begin
        din = 16'hFFFF;
        we = 1'b1;
        r = 1'b0;
      end
      drive(r, we, ae, ie, din, ain);
      if (r)       model = '0;
      else if (we) model = din;
      else if (ae) model = ain;
      else if (ie) model = model + 16'd1;
      step();
      checks++;
      if (dataOut !== model) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, dataOut, model);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #2;
    test_reset();
    test_loads();
    test_priority();
    test_increment();
    test_wrap();
    test_hold_and_sampling();
    test_reset_override();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
